des_dec_key_sched: RTL

- Sequential DES key scheduler for decryption.
- Takes a 64-bit DES key and emits the 16 round subkeys in reverse order, K16 first and K1 last, one subkey per accepted valid/ready handshake.
- Sits ahead of the Feistel round datapath, whose f-function XORs each subkey into the expanded right half before the S-box stage.
- Derives the subkeys by right-rotating C/D, so it needs no 16-entry key storage.

---
 rtl/des_dec_key_sched_if.sv | 21 ++
 rtl/des_dec_key_sched.sv | 121 ++++++++++++
 2 files changed

// File: rtl/des_dec_key_sched_if.sv
// rtl/des_dec_key_sched_if.sv - key load and subkey stream bundle for the decrypt key scheduler
interface des_dec_key_sched_if;
    logic [63:0] key_i;
    logic        load_i;
    logic        ready_o;
    logic [47:0] subkey_o;
    logic        subkey_valid_o;
    logic        subkey_ready_i;
    logic [3:0]  round_o;
    logic        last_o;

    modport master (
        output key_i, load_i, subkey_ready_i,
        input  ready_o, subkey_o, subkey_valid_o, round_o, last_o
    );

    modport slave (
        input  key_i, load_i, subkey_ready_i,
        output ready_o, subkey_o, subkey_valid_o, round_o, last_o
    );
endinterface

// File: rtl/des_dec_key_sched.sv
// rtl/des_dec_key_sched.sv - DES decryption key scheduler emitting K16..K1 by right-rotating C/D
module des_dec_key_sched (
    input  logic                  clk,
    input  logic                  rst,
    des_dec_key_sched_if.slave    bus
);
    // DES bit numbers (1 = MSB) for PC-1 and PC-2, first table entry in the top slice
    localparam logic [56*6-1:0] pc1_tab = {
        6'd57, 6'd49, 6'd41, 6'd33, 6'd25, 6'd17, 6'd9,  6'd1,
        6'd58, 6'd50, 6'd42, 6'd34, 6'd26, 6'd18, 6'd10, 6'd2,
        6'd59, 6'd51, 6'd43, 6'd35, 6'd27, 6'd19, 6'd11, 6'd3,
        6'd60, 6'd52, 6'd44, 6'd36, 6'd63, 6'd55, 6'd47, 6'd39,
        6'd31, 6'd23, 6'd15, 6'd7,  6'd62, 6'd54, 6'd46, 6'd38,
        6'd30, 6'd22, 6'd14, 6'd6,  6'd61, 6'd53, 6'd45, 6'd37,
        6'd29, 6'd21, 6'd13, 6'd5,  6'd28, 6'd20, 6'd12, 6'd4
    };
    localparam logic [48*6-1:0] pc2_tab = {
        6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,  6'd3,  6'd28,
        6'd15, 6'd6,  6'd21, 6'd10, 6'd23, 6'd19, 6'd12, 6'd4,
        6'd26, 6'd8,  6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
        6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55, 6'd30, 6'd40,
        6'd51, 6'd45, 6'd33, 6'd48, 6'd44, 6'd49, 6'd39, 6'd56,
        6'd34, 6'd53, 6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
    };

    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0]     r;
        logic [56*6-1:0] t;
        logic [5:0]      e;
        r = '0;
        t = pc1_tab;
        for (int i = 0; i < 56; i++) begin
            e = t[56*6-1 -: 6];
            t = t << 6;
            r[6'(55 - i)] = k[6'(7'd64 - {1'b0, e})];
        end
        return r;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0]     r;
        logic [48*6-1:0] t;
        logic [5:0]      e;
        r = '0;
        t = pc2_tab;
        for (int i = 0; i < 48; i++) begin
            e = t[48*6-1 -: 6];
            t = t << 6;
            r[6'(47 - i)] = cd[6'(6'd56 - e)];
        end
        return r;
    endfunction

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state, state_nxt;
    logic [27:0] c, d, c_rot, d_rot;
    logic [3:0]  cnt;
    logic [47:0] subkey;
    logic [55:0] cd_load;
    logic        ready, valid, last, hs, rot1;

    assign cd_load = pc1(bus.key_i);
    assign hs      = valid & bus.subkey_ready_i;

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // next state: IDLE -> RUN on load, RUN -> IDLE once K1 is accepted
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.load_i) state_nxt = RUN;
            RUN:     if (hs && cnt == 4'd0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // handshake outputs decoded from registered state only
    always_comb begin
        ready = (state == IDLE);
        valid = (state == RUN);
        last  = valid && (cnt == 4'd0);
    end

    // undo the encrypt-order left shift of the round being left behind
    always_comb begin
        rot1  = (cnt == 4'd15) || (cnt == 4'd8) || (cnt == 4'd1);
        c_rot = rot1 ? {c[0], c[27:1]} : {c[1:0], c[27:2]};
        d_rot = rot1 ? {d[0], d[27:1]} : {d[1:0], d[27:2]};
    end

    // C/D, round counter and subkey register; K16 comes straight from C0/D0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c      <= '0;
            d      <= '0;
            cnt    <= '0;
            subkey <= '0;
        end else if (state == IDLE && bus.load_i) begin
            c      <= cd_load[55:28];
            d      <= cd_load[27:0];
            cnt    <= 4'd15;
            subkey <= pc2(cd_load);
        end else if (hs && cnt != 4'd0) begin
            c      <= c_rot;
            d      <= d_rot;
            cnt    <= cnt - 4'd1;
            subkey <= pc2({c_rot, d_rot});
        end
    end

    assign bus.ready_o        = ready;
    assign bus.subkey_valid_o = valid;
    assign bus.last_o         = last;
    assign bus.round_o        = cnt;
    assign bus.subkey_o       = subkey;
endmodule
